periph_bus_arbiter: RTL and testbench
=====================================

# periph_bus_arbiter

Shares the memory-mapped peripheral bus (LED, switch and similar `chip_select`/`write_enable`/`data_write`/`data_read` drivers) between two requesters: the pipeline's data-memory port (m0) and a debug/loader port (m1). Address decoding, chip-select generation and fair arbitration are performed here. Each access is sequenced through a fixed three-phase FSM that matches the peripherals' registered one-cycle read path. A single completion pulse, with read data, is returned to the winning requester.

## Interface
- `N_DEV`, default 4: number of peripheral slots, 1..16.
- `BASE_HI`, default 16'hFFFF: value of addr[31:16] that selects the peripheral window.
- `DEV_SHIFT`, default 4: the device index is addr[DEV_SHIFT+3 : DEV_SHIFT], giving a 16-byte window per device.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-high reset: 1 = reset.
- `m0_req`, `m1_req`  in  1  access request; held high until the matching ack.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; stable while req is high.
- `m0_addr`, `m1_addr`  in  32  byte address; stable while req is high.
- `m0_wdata`, `m1_wdata`  in  32  write data; stable while req is high.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1  valid with ack; 1 = unmapped address.
- `m0_rdata`, `m1_rdata`  out  32  valid with ack on reads; 0 otherwise.
- `dev_cs`  out  N_DEV  one-hot chip selects, to each driver's `chip_select`.
- `dev_we`  out  1  shared `write_enable`.
- `dev_wdata`  out  32  shared `data_write`.
- `dev_rdata`  in  32*N_DEV  packed `data_read` buses; slot i occupies bits [32i+31:32i].

## Operation
- FSM states:
  - IDLE: wait for a request.
  - ACCESS: drive the device.
  - RESP: return the result to the requester.
- IDLE → ACCESS when any req = 1. On that edge the arbiter latches:
  - the grant;
  - the winning requester's addr, we and wdata;
  - the decoded index;
  - the hit flag.
- Arbitration is round-robin:
  - if only one requester is active, it wins;
  - if both are active, the requester not granted last wins;
  - `last_grant` resets to 1, so m0 wins the first tie.
  - `last_grant` updates on the IDLE → ACCESS edge.
- Hit = (addr[31:16] == BASE_HI) and (index < N_DEV).
- ACCESS, for one cycle:
  - on a hit, `dev_cs[index]` = 1, `dev_we` = latched we, `dev_wdata` = latched wdata;
  - on a miss, `dev_cs` = 0.
  - Next state is always RESP.
- RESP, for one cycle:
  - the granted requester's ack = 1;
  - err = !hit;
  - rdata = dev_rdata slot[index] when the access is a read and a hit, else 0.
  - Next state is always IDLE.
- All non-granted ack/err/rdata outputs are 0.
- `dev_cs` is 0 in IDLE and RESP. `dev_we` and `dev_wdata` are 0 outside ACCESS.

## Timing
- Request high in IDLE during cycle k:
  - `dev_cs` is high in cycle k+1;
  - ack is high in cycle k+2;
  - FSM is IDLE in cycle k+3.
- Fixed 3-cycle latency and a 3-cycle minimum issue interval. No back-to-back overlap.
- The peripheral captures writes and registers `data_read` at the end of cycle k+1. `m_rdata` is a combinational mux of `dev_rdata` in cycle k+2.
- A requester may drop req, or present a new request, in cycle k+3. A req still high in IDLE is treated as a new request.
- Dropping req before ack is a protocol violation. The access still completes and ack still pulses.
- The losing requester waits at most one access, i.e. 3 cycles, then wins the next IDLE cycle.
- Reset is synchronous and overrides everything. In the cycle after reset is asserted:
  - FSM = IDLE;
  - all ack/err/rdata = 0;
  - `dev_cs` = 0, `dev_we` = 0, `dev_wdata` = 0;
  - `last_grant` = 1.
- An access interrupted by reset is dropped: no ack is ever issued for it.

## Test plan
- m0 writes 0x3FF to 0xFFFF_0010 (slot 1):
  - `dev_cs` = 4'b0010, `dev_we` = 1 and `dev_wdata` = 0x3FF in cycle k+1;
  - `m0_ack` = 1 and `m0_err` = 0 in cycle k+2;
  - m1 sees no ack.
- m1 reads 0xFFFF_0000 with slot 0 returning 0x0000_02A5 one cycle after cs:
  - `m1_ack` = 1 and `m1_rdata` = 0x2A5 at k+2;
  - `m0_ack` = 0 throughout.
- Both requesters assert req continuously from reset:
  - grants alternate m0, m1, m0, m1;
  - acks appear at cycles 2, 5, 8, 11.
- m0 reads 0x1234_0000, then 0xFFFF_0050 (index 5 ≥ N_DEV):
  - `dev_cs` stays 0 for both;
  - each access gets `m0_ack` = 1, `m0_err` = 1, `m0_rdata` = 0.
- Reset asserted in the ACCESS cycle:
  - `dev_cs` = 0 and FSM = IDLE next cycle;
  - no ack is issued;
  - the next tie after reset is won by m0.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// rtl/periph_bus_arbiter.sv - two-requester round-robin arbiter and address decoder for the peripheral bus
module periph_bus_arbiter #(
  parameter int          N_DEV     = 4,
  parameter logic [15:0] BASE_HI   = 16'hFFFF,
  parameter int          DEV_SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [31:0]           m0_addr,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [31:0]           m1_addr,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [31:0]           m1_rdata,
  output logic [N_DEV-1:0]      dev_cs,
  output logic                  dev_we,
  output logic [31:0]           dev_wdata,
  input  logic [32*N_DEV-1:0]   dev_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [4:0] N_DEV_W = 5'(N_DEV);

  logic [1:0]  state;
  logic        gnt;          // 0 = m0 owns the current access, 1 = m1
  logic        last_grant;   // requester granted most recently; reset to m1 so m0 wins first tie
  logic        lat_we;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_idx;
  logic        lat_hit;

  logic        pick;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_idx;
  logic        sel_hit;
  logic        unused_addr;
  logic [31:0] slot_data;
  logic [31:0] resp_rdata;

  // Choose the winner for this IDLE cycle and decode its address ahead of the latch edge.
  always_comb begin
    if (m0_req && m1_req) begin
      pick = ~last_grant;
    end else begin
      pick = m1_req;
    end
    sel_addr  = pick ? m1_addr  : m0_addr;
    sel_we    = pick ? m1_we    : m0_we;
    sel_wdata = pick ? m1_wdata : m0_wdata;
    sel_idx   = sel_addr[DEV_SHIFT+3:DEV_SHIFT];
    sel_hit   = (sel_addr[31:16] == BASE_HI) && ({1'b0, sel_idx} < N_DEV_W);
  end

  // Address bits outside the window/index fields carry no meaning here.
  assign unused_addr = ^sel_addr;

  // Three-phase sequencer; the winner's request is captured on the IDLE -> ACCESS edge.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state      <= S_IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      lat_idx    <= '0;
      lat_hit    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            state      <= S_ACCESS;
            gnt        <= pick;
            last_grant <= pick;
            lat_we     <= sel_we;
            lat_wdata  <= sel_wdata;
            lat_idx    <= sel_idx;
            lat_hit    <= sel_hit;
          end
        end
        S_ACCESS: state <= S_RESP;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Drive the device during ACCESS and return the response to the owner during RESP.
  always_comb begin
    dev_cs     = '0;
    dev_we     = 1'b0;
    dev_wdata  = '0;
    slot_data  = '0;
    resp_rdata = '0;
    m0_ack     = 1'b0;
    m0_err     = 1'b0;
    m0_rdata   = '0;
    m1_ack     = 1'b0;
    m1_err     = 1'b0;
    m1_rdata   = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (lat_idx == 4'(i)) begin
        slot_data = dev_rdata[32*i +: 32];
        if (state == S_ACCESS && lat_hit) begin
          dev_cs[i] = 1'b1;
        end
      end
    end
    if (state == S_ACCESS && lat_hit) begin
      dev_we    = lat_we;
      dev_wdata = lat_wdata;
    end
    if (state == S_RESP) begin
      resp_rdata = (lat_hit && !lat_we) ? slot_data : 32'd0;
      if (gnt) begin
        m1_ack   = 1'b1;
        m1_err   = ~lat_hit;
        m1_rdata = resp_rdata;
      end else begin
        m0_ack   = 1'b1;
        m0_err   = ~lat_hit;
        m0_rdata = resp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb/tb_periph_bus_arbiter.sv - directed self-checking bench for periph_bus_arbiter
module tb_periph_bus_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         m0_req, m0_we, m1_req, m1_we;
  logic [31:0]  m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic         m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0]  m0_rdata, m1_rdata;
  logic [3:0]   dev_cs;
  logic         dev_we;
  logic [31:0]  dev_wdata;
  logic [127:0] dev_rdata;

  logic [31:0]  mem [4];
  logic [31:0]  rd  [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  periph_bus_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dev_cs(dev_cs), .dev_we(dev_we), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata)
  );

  // Peripheral model: captures writes and registers read data when selected.
  always @(posedge clk) begin
    if (reset_n) begin
      mem[0] <= 32'h0000_02A5;
      mem[1] <= 32'h0;
      mem[2] <= 32'h2222_2222;
      mem[3] <= 32'h3333_3333;
      for (int i = 0; i < 4; i++) rd[i] <= 32'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (dev_cs[i]) begin
          if (dev_we) mem[i] <= dev_wdata;
          else        rd[i]  <= mem[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) dev_rdata[32*i +: 32] = rd[i];
  end

  task automatic idle_inputs;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic test_reset;
    reset_n = 1;
    idle_inputs();
    m0_req = 1; m0_we = 1; m0_addr = 32'hFFFF_0010; m0_wdata = 32'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (dev_cs !== 4'b0000) begin errors++; $display("FAIL reset_cs: got %b want 0000", dev_cs); end
    checks++; if ({dev_we, dev_wdata} !== 33'h0) begin errors++; $display("FAIL reset_we_wdata: got %b/%h want 0/0", dev_we, dev_wdata); end
    checks++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin errors++; $display("FAIL reset_ack_err: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", m0_rdata, m1_rdata); end
    @(posedge clk); #1;
    reset_n = 0;
    idle_inputs();
  endtask

  task automatic test_read_m1;
    @(posedge clk); #1;
    m1_req = 1; m1_we = 0; m1_addr = 32'hFFFF_0000;
    @(negedge clk);
    checks++; if (dev_cs !== 4'b0000) begin errors++; $display("FAIL rd_cs_k: got %b want 0000", dev_cs); end
    @(negedge clk);
    checks++; if ({dev_cs, dev_we} !== 5'b0001_0) begin errors++; $display("FAIL rd_cs_k1: got %b/%b want 0001/0", dev_cs, dev_we); end
    checks++; if ({m0_ack, m1_ack} !== 2'b00) begin errors++; $display("FAIL rd_ack_k1: got %b want 00", {m0_ack, m1_ack}); end
    @(negedge clk);
    checks++; if ({m0_ack, m1_ack, m1_err} !== 3'b010) begin errors++; $display("FAIL rd_ack_k2: got %b want 010", {m0_ack, m1_ack, m1_err}); end
    checks++; if (m1_rdata !== 32'h0000_02A5) begin errors++; $display("FAIL rd_data: got %h want 000002a5", m1_rdata); end
    checks++; if (dev_cs !== 4'b0000) begin errors++; $display("FAIL rd_cs_k2: got %b want 0000", dev_cs); end
    @(posedge clk); #1;
    m1_req = 0;
    @(negedge clk);
    checks++; if ({m0_ack, m1_ack, dev_cs} !== 6'b0) begin errors++; $display("FAIL rd_k3_idle: got %b want 000000", {m0_ack, m1_ack, dev_cs}); end
  endtask

  task automatic test_write_m0;
    @(posedge clk); #1;
    m0_req = 1; m0_we = 1; m0_addr = 32'hFFFF_0010; m0_wdata = 32'h0000_03FF;
    @(negedge clk);
    @(negedge clk);
    checks++; if (dev_cs !== 4'b0010) begin errors++; $display("FAIL wr_cs: got %b want 0010", dev_cs); end
    checks++; if ({dev_we, dev_wdata} !== {1'b1, 32'h0000_03FF}) begin errors++; $display("FAIL wr_we_wdata: got %b/%h want 1/000003ff", dev_we, dev_wdata); end
    @(negedge clk);
    checks++; if ({m0_ack, m0_err, m1_ack} !== 3'b100) begin errors++; $display("FAIL wr_ack: got %b want 100", {m0_ack, m0_err, m1_ack}); end
    checks++; if ({m0_rdata, dev_we} !== 33'h0) begin errors++; $display("FAIL wr_resp_idle: got %h/%b want 0/0", m0_rdata, dev_we); end
    @(posedge clk); #1;
    m0_req = 0;
  endtask

  task automatic test_unmapped;
    logic [31:0] addrs [2];
    addrs[0] = 32'h1234_0000;
    addrs[1] = 32'hFFFF_0050;
    for (int a = 0; a < 2; a++) begin
      @(posedge clk); #1;
      m0_req = 1; m0_we = 0; m0_addr = addrs[a];
      @(negedge clk);
      @(negedge clk);
      checks++; if ({dev_cs, dev_we} !== 5'b0) begin errors++; $display("FAIL miss_cs_%0d: got %b want 00000", a, {dev_cs, dev_we}); end
      @(negedge clk);
      checks++; if ({m0_ack, m0_err, m1_ack} !== 3'b110) begin errors++; $display("FAIL miss_ack_err_%0d: got %b want 110", a, {m0_ack, m0_err, m1_ack}); end
      checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL miss_rdata_%0d: got %h want 0", a, m0_rdata); end
      @(posedge clk); #1;
      m0_req = 0;
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_ack;
    logic [3:0] exp_cs;
    reset_n = 1;
    m0_req = 1; m0_we = 0; m0_addr = 32'hFFFF_0020;
    m1_req = 1; m1_we = 0; m1_addr = 32'hFFFF_0030;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_ack = (c == 2 || c == 8) ? 2'b10 : (c == 5 || c == 11) ? 2'b01 : 2'b00;
      exp_cs  = (c == 1 || c == 7) ? 4'b0100 : (c == 4 || c == 10) ? 4'b1000 : 4'b0000;
      checks++; if ({m0_ack, m1_ack} !== exp_ack) begin errors++; $display("FAIL rr_ack_c%0d: got %b want %b", c, {m0_ack, m1_ack}, exp_ack); end
      checks++; if (dev_cs !== exp_cs) begin errors++; $display("FAIL rr_cs_c%0d: got %b want %b", c, dev_cs, exp_cs); end
      if (exp_ack == 2'b10) begin
        checks++; if (m0_rdata !== 32'h2222_2222) begin errors++; $display("FAIL rr_m0_rdata_c%0d: got %h want 22222222", c, m0_rdata); end
      end
      if (exp_ack == 2'b01) begin
        checks++; if (m1_rdata !== 32'h3333_3333) begin errors++; $display("FAIL rr_m1_rdata_c%0d: got %h want 33333333", c, m1_rdata); end
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'hFFFF_0000;
    @(negedge clk);
    @(negedge clk);
    checks++; if (dev_cs !== 4'b0001) begin errors++; $display("FAIL rst_mid_access_cs: got %b want 0001", dev_cs); end
    reset_n = 1;
    @(posedge clk); #1;
    m0_req = 0;
    @(negedge clk);
    checks++; if ({dev_cs, m0_ack, m1_ack} !== 6'b0) begin errors++; $display("FAIL rst_mid_after: got %b want 000000", {dev_cs, m0_ack, m1_ack}); end
    @(posedge clk); #1;
    reset_n = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if ({m0_ack, m1_ack} !== 2'b00) begin errors++; $display("FAIL rst_mid_no_ack_%0d: got %b want 00", c, {m0_ack, m1_ack}); end
    end
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'hFFFF_0020;
    m1_req = 1; m1_we = 0; m1_addr = 32'hFFFF_0030;
    @(negedge clk);
    @(negedge clk);
    checks++; if (dev_cs !== 4'b0100) begin errors++; $display("FAIL rst_tie_cs: got %b want 0100", dev_cs); end
    @(negedge clk);
    checks++; if ({m0_ack, m1_ack} !== 2'b10) begin errors++; $display("FAIL rst_tie_ack: got %b want 10", {m0_ack, m1_ack}); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_m1();
    test_write_m0();
    test_unmapped();
    test_round_robin();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
